inst_fetch_bridge: RTL and testbench
====================================

Name: inst_fetch_bridge

Overview:
- Sits between the core's instruction-fetch port (rom_ce_o / rom_addr_o / rom_data_i) and a multi-cycle instruction memory that uses a req/ack handshake.
- Holds a one-entry fetch line (tag + data). A hit returns the instruction combinationally.
- A miss raises a stall request toward the pipeline and runs a bus transaction. A timeout counter guards against a memory that never acknowledges.
- Fully synchronous to the core clock.

Parameters:
- ADDR_W, 32, fetch address width (InstAddrBus).
- DATA_W, 32, instruction width (InstBus).
- TIMEOUT, 16, number of bus-wait cycles before the fill is abandoned. Legal range 2..255.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: one clock, asynchronous, active-high (1 = RstEnable).
- ce_i  in  1  fetch enable from pc_reg.
- addr_i  in  ADDR_W  fetch address from pc_reg.
- flush_i  in  1  invalidate the fetch line.
- data_o  out  DATA_W  instruction to if_id.
- stall_o  out  1  stall request to pipeline control.
- err_o  out  1  one-cycle pulse on bus timeout.
- bus_req_o  out  1  memory request.
- bus_addr_o  out  ADDR_W  memory address.
- bus_ack_i  in  1  memory acknowledge; data valid in the same cycle.
- bus_data_i  in  DATA_W  memory read data.

Behaviour:
- Reset values (asynchronous): state=IDLE, valid=0, tag=0, line=0, cnt=0, bus_req_o=0, bus_addr_o=0, err_o=0.
- Combinational outputs: data_o=0 and stall_o=0 while in reset.
- Hit = ce_i & valid & (tag==addr_i). Hit → data_o=line, stall_o=0, zero latency.
- ce_i=0 → data_o=0 (ZeroWord), stall_o=0, no new request.
- Miss (ce_i & !hit) → stall_o=1 combinationally in the same cycle. data_o=0 while stalled.
- FSM has states IDLE and REQ.
- IDLE → REQ on a miss with flush_i=0. At that edge: bus_addr_o←addr_i, bus_req_o←1, cnt←0.
- REQ holds bus_req_o and bus_addr_o stable until exit. This holds even if ce_i drops or addr_i changes; the bus protocol forbids withdrawing a request.
- REQ with bus_ack_i=1 → tag←bus_addr_o, line←bus_data_i, valid←1, bus_req_o←0, state←IDLE.
- REQ with no ack and cnt==TIMEOUT-1 → tag←bus_addr_o, line←0 (NOP), valid←1, err_o←1 for one cycle, bus_req_o←0, state←IDLE.
- Otherwise in REQ, cnt←cnt+1. cnt is 8 bits and never wraps, because exit happens at TIMEOUT-1.
- Minimum miss penalty is 2 cycles: miss seen in cycle 0, req in cycle 1 with ack, hit in cycle 2.
- A fill completes for bus_addr_o, not addr_i. If addr_i changed meanwhile, the next cycle is a fresh miss.
- flush_i → valid←0 at the next edge, in any state. If flush_i coincides with a fill edge, flush wins (valid=0) and tag/line are still written.
- flush_i in IDLE suppresses the launch of a new request that cycle.
- stall_o is never asserted while ce_i=0.
- err_o is 0 in every cycle except the one following a timeout exit.

Decomposition:
- Shared defs header additions:
  - InstFetchIdle/InstFetchReq state encodings (1 bit).
  - FetchTimeoutDefault.
  - Reuses RstEnable, ChipEnable, ZeroWord, InstAddrBus, InstBus.
- Single module; no sub-module is needed. The timeout counter is inline.
- pipeline control (ctrl) consumes stall_o as its IF-stage stall request.

Test Plan:
- Reset then ce_i=1, addr_i=0x0 → stall_o=1 in the same cycle. bus_req_o=1, bus_addr_o=0x0 next cycle. ack with data 0x34011100 → following cycle stall_o=0, data_o=0x34011100.
- Repeat addr 0x0 after the fill → no bus_req_o, data_o=0x34011100, stall_o=0.
- addr 0x4, ack delayed 5 cycles → bus_req_o held 5 cycles with bus_addr_o=0x4 stable, stall_o=1 throughout, then hit.
- addr 0x8, no ack, TIMEOUT=16 → bus_req_o drops after 16 req cycles, err_o pulses exactly 1 cycle, data_o=0 with stall_o=0 on the next cycle.
- flush_i asserted on the ack edge for addr 0xC → line not valid. Next cycle with addr 0xC is a miss, with a new request issued.
- rst asserted mid-REQ (asynchronous, between edges) → bus_req_o=0 and stall_o=0 immediately. No err_o, valid=0 after release.

Source files
------------

// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the instruction fetch bridge: bus widths, the
// core-wide enable/reset polarities and the fill state machine encoding.
package inst_fetch_bridge_pkg;

   localparam int InstAddrBus = 32;
   localparam int InstBus = 32;

   localparam logic RstEnable = 1'b1;
   localparam logic ChipEnable = 1'b1;
   localparam logic [InstBus-1:0] ZeroWord = 32'h0000_0000;

   localparam int FetchTimeoutDefault = 16;

   typedef enum logic {
      InstFetchIdle = 1'b0,
      InstFetchReq = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/inst_fetch_bridge.sv
// One-entry instruction fetch line between the core fetch port and a
// multi-cycle req/ack instruction memory, with a bus timeout guard.
module inst_fetch_bridge
   import inst_fetch_bridge_pkg::*;
#(
   parameter int ADDR_W = InstAddrBus,
   parameter int DATA_W = InstBus,
   parameter int TIMEOUT = FetchTimeoutDefault
) (
   input logic clk,
   input logic rst,
   input logic ce_i,
   input logic [ADDR_W-1:0] addr_i,
   input logic flush_i,
   output logic [DATA_W-1:0] data_o,
   output logic stall_o,
   output logic err_o,
   output logic bus_req_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   input logic bus_ack_i,
   input logic [DATA_W-1:0] bus_data_i
);

   // The counter starts at zero on launch, so the last waiting cycle is TIMEOUT-1.
   localparam logic [7:0] LastCnt = 8'(TIMEOUT - 1);

   fetch_state_e r_state;
   fetch_state_e w_nextState;

   logic r_valid;
   logic [ADDR_W-1:0] r_tag;
   logic [DATA_W-1:0] r_line;
   logic [7:0] r_cnt;
   logic r_busReq;
   logic [ADDR_W-1:0] r_busAddr;
   logic r_err;

   logic w_hit;
   logic w_miss;
   logic w_launch;
   logic w_fillAck;
   logic w_timeout;

   assign bus_req_o = r_busReq;
   assign bus_addr_o = r_busAddr;
   assign err_o = r_err;

   // Hit/miss decode and the zero-latency fetch response; quiet while in reset.
   always_comb begin
      w_hit = 1'b0;
      w_miss = 1'b0;
      data_o = '0;
      stall_o = 1'b0;
      if (rst != RstEnable) begin
         w_hit = (ce_i == ChipEnable) && r_valid && (r_tag == addr_i);
         w_miss = (ce_i == ChipEnable) && !w_hit;
         data_o = w_hit ? r_line : '0;
         stall_o = w_miss;
      end
   end

   // Fill state machine: launch on an unflushed miss, leave on ack or timeout.
   always_comb begin
      w_nextState = r_state;
      w_launch = 1'b0;
      w_fillAck = 1'b0;
      w_timeout = 1'b0;
      unique case (r_state)
         InstFetchIdle: begin
            if (w_miss && !flush_i) begin
               w_launch = 1'b1;
               w_nextState = InstFetchReq;
            end
         end
         InstFetchReq: begin
            if (bus_ack_i) begin
               w_fillAck = 1'b1;
               w_nextState = InstFetchIdle;
            end else if (r_cnt == LastCnt) begin
               w_timeout = 1'b1;
               w_nextState = InstFetchIdle;
            end
         end
         default: w_nextState = InstFetchIdle;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_state <= InstFetchIdle;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Line, bus request and timeout bookkeeping. The request stays put until
   // exit because the bus cannot withdraw it; a flush on the fill edge still
   // lets tag/line be written but leaves the line invalid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst == RstEnable) begin
         r_valid <= 1'b0;
         r_tag <= '0;
         r_line <= '0;
         r_cnt <= '0;
         r_busReq <= 1'b0;
         r_busAddr <= '0;
         r_err <= 1'b0;
      end else begin
         r_err <= w_timeout;
         if (w_launch) begin
            r_busAddr <= addr_i;
            r_busReq <= 1'b1;
            r_cnt <= '0;
         end
         if (w_fillAck) begin
            r_tag <= r_busAddr;
            r_line <= bus_data_i;
            r_valid <= 1'b1;
            r_busReq <= 1'b0;
         end else if (w_timeout) begin
            r_tag <= r_busAddr;
            r_line <= '0;
            r_valid <= 1'b1;
            r_busReq <= 1'b0;
         end else if (r_state == InstFetchReq) begin
            r_cnt <= r_cnt + 8'd1;
         end
         if (flush_i) begin
            r_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench for inst_fetch_bridge: directed scenarios followed by
// random traffic, all compared against a behavioural model of the fetch line.
module tb_inst_fetch_bridge;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 16;

   logic clk;
   logic rst;
   logic ce_i;
   logic [AW-1:0] addr_i;
   logic flush_i;
   logic [DW-1:0] data_o;
   logic stall_o;
   logic err_o;
   logic bus_req_o;
   logic [AW-1:0] bus_addr_o;
   logic bus_ack_i;
   logic [DW-1:0] bus_data_i;

   int checks = 0;
   int errors = 0;

   // Behavioural model: the cached line plus the one outstanding bus request.
   logic mValid;
   logic [AW-1:0] mTag;
   logic [DW-1:0] mLine;
   logic mPending;
   logic [AW-1:0] mReqAddr;
   int mReqCycles;
   logic mErr;

   inst_fetch_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .ce_i(ce_i),
      .addr_i(addr_i),
      .flush_i(flush_i),
      .data_o(data_o),
      .stall_o(stall_o),
      .err_o(err_o),
      .bus_req_o(bus_req_o),
      .bus_addr_o(bus_addr_o),
      .bus_ack_i(bus_ack_i),
      .bus_data_i(bus_data_i)
   );

   // Free-running core clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      mValid = 1'b0;
      mTag = '0;
      mLine = '0;
      mPending = 1'b0;
      mReqAddr = '0;
      mReqCycles = 0;
      mErr = 1'b0;
   endtask

   function automatic logic modelHit();
      return ce_i && mValid && (mTag == addr_i);
   endfunction

   task automatic checkOutput(input string tag);
      logic [DW-1:0] expData;
      logic expStall;
      if (rst) begin
         expData = '0;
         expStall = 1'b0;
      end else begin
         expData = modelHit() ? mLine : '0;
         expStall = ce_i && !modelHit();
      end
      checkOne({tag, ".data"}, data_o, expData);
      checkOne({tag, ".stall"}, 32'(stall_o), 32'(expStall));
      checkOne({tag, ".req"}, 32'(bus_req_o), 32'(mPending));
      checkOne({tag, ".baddr"}, bus_addr_o, mReqAddr);
      checkOne({tag, ".err"}, 32'(err_o), 32'(mErr));
   endtask

   // Advance the model across one clock edge using the inputs held during the cycle.
   task automatic modelEdge();
      logic hit;
      if (rst) begin
         modelReset();
         return;
      end
      hit = modelHit();
      mErr = 1'b0;
      if (mPending) begin
         mReqCycles++;
         if (bus_ack_i) begin
            mTag = mReqAddr;
            mLine = bus_data_i;
            mValid = 1'b1;
            mPending = 1'b0;
         end else if (mReqCycles == TO) begin
            mTag = mReqAddr;
            mLine = '0;
            mValid = 1'b1;
            mPending = 1'b0;
            mErr = 1'b1;
         end
      end else if (ce_i && !hit && !flush_i) begin
         mPending = 1'b1;
         mReqAddr = addr_i;
         mReqCycles = 0;
      end
      if (flush_i) mValid = 1'b0;
   endtask

   task automatic applyStimulus(input logic ce, input logic [AW-1:0] addr, input logic flush,
                                input logic ack, input logic [DW-1:0] data);
      ce_i = ce;
      addr_i = addr;
      flush_i = flush;
      bus_ack_i = ack;
      bus_data_i = data;
   endtask

   task automatic runCycle(input string tag, input logic ce, input logic [AW-1:0] addr,
                           input logic flush, input logic ack, input logic [DW-1:0] data);
      applyStimulus(ce, addr, flush, ack, data);
      @(negedge clk);
      checkOutput(tag);
      @(posedge clk);
      modelEdge();
      #1;
   endtask

   // Directed scenarios, then random traffic.
   initial begin
      int reqSeen;
      logic [AW-1:0] addrSet [5];
      addrSet[0] = 32'h0; addrSet[1] = 32'h4; addrSet[2] = 32'h8;
      addrSet[3] = 32'hC; addrSet[4] = 32'h10;

      rst = 1'b1;
      applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0);
      modelReset();
      repeat (2) runCycle("reset", 1'b1, 32'h10, 1'b0, 1'b0, '0);
      rst = 1'b0;

      $display("[TB] first fill of 0x0");
      runCycle("miss0", 1'b1, 32'h0, 1'b0, 1'b0, '0);
      runCycle("req0", 1'b1, 32'h0, 1'b0, 1'b1, 32'h34011100);
      applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOne("hit0.direct", data_o, 32'h34011100);
      checkOne("hit0.nostall", 32'(stall_o), 32'd0);
      @(posedge clk); modelEdge(); #1;
      runCycle("hit0.again", 1'b1, 32'h0, 1'b0, 1'b0, '0);
      runCycle("idle.ce0", 1'b0, 32'h0, 1'b0, 1'b0, '0);

      $display("[TB] delayed ack for 0x4 with address wander");
      runCycle("miss4", 1'b1, 32'h4, 1'b0, 1'b0, '0);
      runCycle("wait4a", 1'b1, 32'h4, 1'b0, 1'b0, 32'hDEAD0001);
      runCycle("wait4b", 1'b1, 32'h40, 1'b0, 1'b0, 32'hDEAD0002);
      runCycle("wait4c", 1'b0, 32'h4, 1'b0, 1'b0, 32'hDEAD0003);
      runCycle("wait4d", 1'b1, 32'h4, 1'b0, 1'b0, 32'hDEAD0004);
      runCycle("ack4", 1'b1, 32'h4, 1'b0, 1'b1, 32'h20420005);
      runCycle("hit4", 1'b1, 32'h4, 1'b0, 1'b0, '0);

      $display("[TB] timeout on 0x8");
      runCycle("miss8", 1'b1, 32'h8, 1'b0, 1'b0, '0);
      reqSeen = 0;
      for (int i = 0; i < TO; i++) begin
         applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, 32'h1234_0000 + 32'(i));
         @(negedge clk);
         if (bus_req_o) reqSeen++;
         checkOutput("wait8");
         @(posedge clk); modelEdge(); #1;
      end
      checkOne("timeout.reqcycles", 32'(reqSeen), 32'(TO));
      applyStimulus(1'b1, 32'h8, 1'b0, 1'b0, '0);
      @(negedge clk);
      checkOne("timeout.err", 32'(err_o), 32'd1);
      checkOne("timeout.req", 32'(bus_req_o), 32'd0);
      checkOne("timeout.nop", data_o, 32'h0);
      checkOne("timeout.nostall", 32'(stall_o), 32'd0);
      @(posedge clk); modelEdge(); #1;
      runCycle("after8", 1'b1, 32'h8, 1'b0, 1'b0, '0);

      $display("[TB] flush on the fill edge for 0xC");
      runCycle("missC", 1'b1, 32'hC, 1'b0, 1'b0, '0);
      runCycle("ackFlushC", 1'b1, 32'hC, 1'b1, 1'b1, 32'h55AA55AA);
      runCycle("remissC", 1'b1, 32'hC, 1'b0, 1'b0, '0);
      runCycle("reqC", 1'b1, 32'hC, 1'b0, 1'b1, 32'h66BB66BB);
      runCycle("hitC", 1'b1, 32'hC, 1'b0, 1'b0, '0);

      $display("[TB] flush in idle suppresses launch");
      runCycle("flushIdle", 1'b1, 32'h20, 1'b1, 1'b0, '0);
      runCycle("afterFlush", 1'b1, 32'h20, 1'b0, 1'b0, '0);
      runCycle("ack20", 1'b1, 32'h20, 1'b0, 1'b1, 32'h0BAD0020);

      $display("[TB] asynchronous reset mid request");
      runCycle("miss10", 1'b1, 32'h10, 1'b0, 1'b0, '0);
      runCycle("wait10", 1'b1, 32'h10, 1'b0, 1'b0, '0);
      #2 rst = 1'b1;
      #1;
      checkOne("asyncRst.req", 32'(bus_req_o), 32'd0);
      checkOne("asyncRst.stall", 32'(stall_o), 32'd0);
      modelReset();
      rst = 1'b0;
      runCycle("postRst", 1'b0, 32'h10, 1'b0, 1'b0, '0);
      runCycle("postRstMiss", 1'b1, 32'h0, 1'b0, 1'b0, '0);
      runCycle("postRstAck", 1'b1, 32'h0, 1'b0, 1'b1, 32'h77);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         runCycle("rand",
                  ($urandom_range(0, 9) < 8),
                  addrSet[$urandom_range(0, 4)],
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 9) < 2),
                  $urandom);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
